// File: rtl/seq_shifter_if.sv
// Shift unit handshake bundle.
// The master drives requests; the slave returns status and result.
interface seq_shifter_if;
   logic        Start;
   logic [1:0]  ShiftOp;
   logic [31:0] Operand;
   logic [31:0] ShiftAmt;
   logic        Flush;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;

   modport master (
      output Start, ShiftOp, Operand, ShiftAmt, Flush,
      input  Busy, Done, Result
   );

   modport slave (
      input  Start, ShiftOp, Operand, ShiftAmt, Flush,
      output Busy, Done, Result
   );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-free shifter: one bit per cycle.
// SLL/SRL/SRA/ROTR, amount from ShiftAmt[4:0].
module seq_shifter (
   input  logic       Clk,
   input  logic       Rst,
   seq_shifter_if.slave bus
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]  state;
   logic [31:0] work;
   logic [31:0] shifted;
   logic [1:0]  op;
   logic [4:0]  cnt;
   logic        busy;
   logic        done;
   logic [31:0] result;

   // Upper amount bits carry no meaning for a 32-bit shift.
   logic unused_amt;
   assign unused_amt = ^bus.ShiftAmt[31:5];

   // One-bit step of the working value for the captured op.
   always_comb begin
      shifted = work;
      unique case (op)
         2'b00:   shifted = {work[30:0], 1'b0};
         2'b01:   shifted = {1'b0, work[31:1]};
         2'b10:   shifted = {work[31], work[31:1]};
         default: shifted = {work[0], work[31:1]};
      endcase
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state  <= IDLE;
         work   <= '0;
         op     <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.Start && !bus.Flush) begin
                  work  <= bus.Operand;
                  op    <= bus.ShiftOp;
                  cnt   <= bus.ShiftAmt[4:0];
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            default: begin
               if (bus.Flush) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (cnt != 5'd0) begin
                  work <= shifted;
                  cnt  <= cnt - 5'd1;
               end else begin
                  result <= work;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

   assign bus.Busy   = busy;
   assign bus.Done   = done;
   assign bus.Result = result;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter.
// Expected results queued on accept, compared on Done.
module tb_seq_shifter;

   logic Clk;
   logic Rst;
   seq_shifter_if bus ();

   seq_shifter dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] prev_res;
   logic        rst_q;
   int          busy_cnt;
   int          lat;

   task automatic check(input string tag,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op,
                                         input logic [31:0] v,
                                         input logic [31:0] amt);
      logic [4:0]  a;
      logic [63:0] dbl;
      a = amt[4:0];
      dbl = {v, v} >> a;
      case (op)
         2'b00:   return v << a;
         2'b01:   return v >> a;
         2'b10:   return 32'($signed(v) >>> a);
         default: return dbl[31:0];
      endcase
   endfunction

   always @(posedge Clk) rst_q = Rst;

   // Monitor: compare on Done, and Result must not move otherwise.
   always @(negedge Clk) begin
      if (!Rst && !rst_q) begin
         if (bus.Done) begin
            if (exp_q.size() == 0)
               check("spurious_done", 32'd1, 32'd0);
            else
               check("result", bus.Result, exp_q.pop_front());
         end else begin
            check("result_stable", bus.Result, prev_res);
         end
      end
      prev_res = bus.Result;
   end

   task automatic start_op(input logic [1:0] op,
                           input logic [31:0] v,
                           input logic [31:0] amt);
      bus.Start    = 1'b1;
      bus.ShiftOp  = op;
      bus.Operand  = v;
      bus.ShiftAmt = amt;
      exp_q.push_back(model(op, v, amt));
      @(posedge Clk);
      #1;
      bus.Start    = 1'b0;
      bus.ShiftOp  = 2'($urandom);
      bus.Operand  = $urandom;
      bus.ShiftAmt = $urandom;
   endtask

   // Returns at the negedge where Done is seen; lat = edges after accept.
   task automatic wait_done(input string tag, input int exp_lat);
      bit seen;
      seen = 1'b0;
      busy_cnt = 0;
      lat = 0;
      for (int n = 1; n <= exp_lat + 6; n++) begin
         @(negedge Clk);
         if (bus.Done) begin
            lat = n - 1;
            seen = 1'b1;
            break;
         end
         if (bus.Busy) busy_cnt++;
      end
      if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
      else check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      Rst = 1'b1;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      bus.ShiftOp = 2'b00;
      bus.Operand = '0;
      bus.ShiftAmt = '0;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_busy", 32'(bus.Busy), 32'd0);
      check("rst_done", 32'(bus.Done), 32'd0);
      check("rst_result", bus.Result, 32'd0);
      Rst = 1'b0;

      // SLL 1 by 4
      start_op(2'b00, 32'h1, 32'd4);
      wait_done("sll4", 5);
      check("sll4_busy_cycles", 32'(busy_cnt), 32'd5);
      check("sll4_value", bus.Result, 32'h10);
      @(posedge Clk); #1;
      check("done_one_cycle", 32'(bus.Done), 32'd0);

      // SRA / SRL 0x80000000 by 31
      start_op(2'b10, 32'h8000_0000, 32'd31);
      wait_done("sra31", 32);
      check("sra31_value", bus.Result, 32'hFFFF_FFFF);
      @(posedge Clk); #1;
      start_op(2'b01, 32'h8000_0000, 32'd31);
      wait_done("srl31", 32);
      check("srl31_value", bus.Result, 32'h1);
      @(posedge Clk); #1;

      // amount 0, upper amount bits ignored
      start_op(2'b10, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
      wait_done("amt0", 1);
      check("amt0_value", bus.Result, 32'hDEAD_BEEF);
      @(posedge Clk); #1;

      // ROTR then back-to-back ROTR in the Done cycle
      start_op(2'b11, 32'h1, 32'd1);
      wait_done("rotr1", 2);
      check("rotr1_value", bus.Result, 32'h8000_0000);
      start_op(2'b11, 32'h1234_5678, 32'd8);
      wait_done("rotr8", 9);
      check("rotr8_value", bus.Result, 32'h7812_3456);
      @(posedge Clk); #1;

      // Flush on 3rd SHIFT cycle, Start pulsed while busy
      start_op(2'b00, 32'h0000_0003, 32'd10);
      bus.Start = 1'b1;
      bus.Operand = 32'hFFFF_FFFF;
      bus.ShiftAmt = 32'd0;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      @(posedge Clk); #1;
      bus.Flush = 1'b1;
      @(posedge Clk); #1;
      bus.Flush = 1'b0;
      void'(exp_q.pop_back());
      check("flush_busy", 32'(bus.Busy), 32'd0);
      check("flush_done", 32'(bus.Done), 32'd0);
      check("flush_result", bus.Result, 32'h7812_3456);
      repeat (14) @(posedge Clk);
      #1;
      check("flush_no_done_busy", 32'(bus.Busy), 32'd0);

      // Flush beats Start in IDLE
      bus.Start = 1'b1;
      bus.Flush = 1'b1;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      check("flush_prio_busy", 32'(bus.Busy), 32'd0);

      // Reset mid-SRA, then immediate restart
      start_op(2'b10, 32'hF000_0000, 32'd12);
      repeat (4) @(posedge Clk);
      #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      void'(exp_q.pop_back());
      check("midrst_busy", 32'(bus.Busy), 32'd0);
      check("midrst_done", 32'(bus.Done), 32'd0);
      check("midrst_result", bus.Result, 32'd0);
      start_op(2'b01, 32'hF000_0000, 32'd4);
      wait_done("postrst", 5);
      check("postrst_value", bus.Result, 32'h0F00_0000);
      @(posedge Clk); #1;

      // Random back-to-back ops, checked by the monitor
      for (int i = 0; i < 12; i++) begin
         logic [31:0] amt;
         amt = $urandom;
         start_op(2'($urandom), $urandom, amt);
         wait_done("rand", int'(amt[4:0]) + 1);
      end
      @(posedge Clk); #1;
      repeat (3) @(posedge Clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
